// File: rtl/aud_mix_multi.sv
// N-source stereo mixer: per-source gain, time-multiplexed MAC, master attenuation, clamp.
// Optional macro AUD_MIX_RAMP_EN enables click-free per-source gain ramping.
module aud_mix_multi #(
    parameter int NCH = 4,
    parameter int DW  = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sample_ce,
    input  logic [NCH*DW-1:0]   in_l,
    input  logic [NCH*DW-1:0]   in_r,
    input  logic [NCH-1:0]      is_signed,
    input  logic [NCH*8-1:0]    gain,
    input  logic [4:0]          master_att,
    input  logic                ovr_clr,
    output logic [DW-1:0]       out_l,
    output logic [DW-1:0]       out_r,
    output logic                out_valid,
    output logic                busy,
    output logic                overrun,
    output logic                clip
);
    localparam int KW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW = DW + 9;
    localparam int AW = DW + 9 + $clog2(NCH);
    localparam logic signed [AW-1:0] SMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CAP   = 3'd1,
        S_ACC   = 3'd2,
        S_SCALE = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    function automatic logic [7:0] sat_gain(input logic [7:0] g);
        if (g > 8'd128) sat_gain = 8'd128;
        else            sat_gain = g;
    endfunction

    // Offset binary becomes two's complement by flipping the MSB.
    function automatic logic [DW-1:0] to_signed(input logic [DW-1:0] x, input logic s);
        if (s) to_signed = x;
        else   to_signed = {~x[DW-1], x[DW-2:0]};
    endfunction

    function automatic logic is_clamped(input logic signed [AW-1:0] v);
        is_clamped = (v > SMAX) || (v < SMIN);
    endfunction

    function automatic logic [DW-1:0] clamp_f(input logic signed [AW-1:0] v);
        if (v > SMAX)      clamp_f = {1'b0, {(DW-1){1'b1}}};
        else if (v < SMIN) clamp_f = {1'b1, {(DW-1){1'b0}}};
        else               clamp_f = v[DW-1:0];
    endfunction

    state_t                     state_q, state_d;
    logic [KW-1:0]              k_q, k_d;
    logic [NCH-1:0][DW-1:0]     sl_q, sl_d, sr_q, sr_d;
    logic [NCH-1:0][7:0]        g_q, g_d;
    logic signed [AW-1:0]       acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic signed [AW-1:0]       r_l_q, r_l_d, r_r_q, r_r_d;
    logic [DW-1:0]              out_l_q, out_l_d, out_r_q, out_r_d;
    logic                       out_valid_q, out_valid_d;
    logic                       busy_q, busy_d;
    logic                       overrun_q, overrun_d;
    logic                       clip_q, clip_d;
    logic signed [DW-1:0]       xl_s, xr_s;
    logic signed [PW-1:0]       gx_s, pl_s, pr_s;
    logic [7:0]                 tgt_s;
`ifdef AUD_MIX_RAMP_EN
    logic [NCH-1:0][7:0]        c_q, c_d;
`endif

    // Next-state, datapath and output computation for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        sl_d        = sl_q;
        sr_d        = sr_q;
        g_d         = g_q;
        acc_l_d     = acc_l_q;
        acc_r_d     = acc_r_q;
        r_l_d       = r_l_q;
        r_r_d       = r_r_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        out_valid_d = 1'b0;
        clip_d      = clip_q;
        tgt_s       = 8'd0;
`ifdef AUD_MIX_RAMP_EN
        c_d         = c_q;
`endif
        xl_s = sl_q[k_q];
        xr_s = sr_q[k_q];
        gx_s = PW'({1'b0, g_q[k_q]});
        pl_s = PW'(xl_s) * gx_s;
        pr_s = PW'(xr_s) * gx_s;

        case (state_q)
            S_IDLE: begin
                if (sample_ce) state_d = S_CAP;
                else           state_d = S_IDLE;
            end
            S_CAP: begin
                for (int i = 0; i < NCH; i++) begin
                    sl_d[i] = to_signed(in_l[i*DW +: DW], is_signed[i]);
                    sr_d[i] = to_signed(in_r[i*DW +: DW], is_signed[i]);
`ifdef AUD_MIX_RAMP_EN
                    g_d[i]  = c_q[i];
`else
                    g_d[i]  = sat_gain(gain[i*8 +: 8]);
`endif
                end
                acc_l_d = '0;
                acc_r_d = '0;
                k_d     = '0;
                state_d = S_ACC;
            end
            S_ACC: begin
                acc_l_d = acc_l_q + AW'(pl_s);
                acc_r_d = acc_r_q + AW'(pr_s);
                if (k_q == KW'(NCH - 1)) begin
                    state_d = S_SCALE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_SCALE: begin
                if (master_att[4]) begin
                    r_l_d = '0;
                    r_r_d = '0;
                end else begin
                    r_l_d = (acc_l_q >>> 4'd7) >>> master_att[3:0];
                    r_r_d = (acc_r_q >>> 4'd7) >>> master_att[3:0];
                end
                state_d = S_OUT;
            end
            S_OUT: begin
                out_l_d     = clamp_f(r_l_q);
                out_r_d     = clamp_f(r_r_q);
                clip_d      = is_clamped(r_l_q) | is_clamped(r_r_q);
                out_valid_d = 1'b1;
`ifdef AUD_MIX_RAMP_EN
                // Each current gain steps one LSB toward its saturated target.
                for (int i = 0; i < NCH; i++) begin
                    tgt_s = sat_gain(gain[i*8 +: 8]);
                    if (c_q[i] < tgt_s)      c_d[i] = c_q[i] + 8'd1;
                    else if (c_q[i] > tgt_s) c_d[i] = c_q[i] - 8'd1;
                    else                     c_d[i] = c_q[i];
                end
`endif
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        if (sample_ce && (state_q != S_IDLE)) overrun_d = 1'b1;
        else if (ovr_clr)                     overrun_d = 1'b0;
        else                                  overrun_d = overrun_q;
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            sl_q        <= '0;
            sr_q        <= '0;
            g_q         <= '0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            r_l_q       <= '0;
            r_r_q       <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            clip_q      <= 1'b0;
`ifdef AUD_MIX_RAMP_EN
            c_q         <= '0;
`endif
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            sl_q        <= sl_d;
            sr_q        <= sr_d;
            g_q         <= g_d;
            acc_l_q     <= acc_l_d;
            acc_r_q     <= acc_r_d;
            r_l_q       <= r_l_d;
            r_r_q       <= r_r_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            clip_q      <= clip_d;
`ifdef AUD_MIX_RAMP_EN
            c_q         <= c_d;
`endif
        end
    end

    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign clip      = clip_q;
endmodule

// File: tb/tb_aud_mix_multi.sv
// Scoreboard bench for aud_mix_multi: arithmetic reference model, random and directed frames.
module tb_aud_mix_multi;
    localparam int NCH = 4;
    localparam int DW  = 16;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                sample_ce = 1'b0;
    logic [NCH*DW-1:0]   in_l = '0;
    logic [NCH*DW-1:0]   in_r = '0;
    logic [NCH-1:0]      is_signed = '1;
    logic [NCH*8-1:0]    gain = '0;
    logic [4:0]          master_att = 5'd0;
    logic                ovr_clr = 1'b0;
    logic [DW-1:0]       out_l, out_r;
    logic                out_valid, busy, overrun, clip;

    aud_mix_multi #(.NCH(NCH), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n), .sample_ce(sample_ce),
        .in_l(in_l), .in_r(in_r), .is_signed(is_signed), .gain(gain),
        .master_att(master_att), .ovr_clr(ovr_clr),
        .out_l(out_l), .out_r(out_r), .out_valid(out_valid),
        .busy(busy), .overrun(overrun), .clip(clip)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        bit            clp;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] last_l = '0;
    logic [DW-1:0] last_r = '0;
    bit            last_clip = 1'b0;
    bit            hold_en = 1'b0;
    int            c_m[NCH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int sat_g(input int g);
        return (g > 128) ? 128 : g;
    endfunction

    function automatic int to_int(input logic [DW-1:0] x, input bit s);
        int half;
        half = 1 << (DW - 1);
        if (s) return (int'(x) >= half) ? int'(x) - 2 * half : int'(x);
        return int'(x) - half;
    endfunction

    function automatic logic [DW-1:0] clampv(input longint v, output bit c);
        longint mx, mn;
        mx = (longint'(1) << (DW - 1)) - 1;
        mn = -(longint'(1) << (DW - 1));
        c = (v > mx) || (v < mn);
        if (v > mx) return DW'(mx);
        if (v < mn) return DW'(mn);
        return DW'(v);
    endfunction

    // Reference: weighted sum, divide by 128 * 2^att with floor, clamp.
    task automatic push_expected();
        longint sl, sr, rl, rr;
        int g;
        bit cl, cr;
        exp_t e;
        sl = 0;
        sr = 0;
        for (int i = 0; i < NCH; i++) begin
`ifdef AUD_MIX_RAMP_EN
            g = c_m[i];
`else
            g = sat_g(int'(gain[i*8 +: 8]));
`endif
            sl += longint'(to_int(in_l[i*DW +: DW], is_signed[i])) * g;
            sr += longint'(to_int(in_r[i*DW +: DW], is_signed[i])) * g;
        end
        if (master_att[4]) begin
            rl = 0;
            rr = 0;
        end else begin
            rl = sl >>> (7 + int'(master_att[3:0]));
            rr = sr >>> (7 + int'(master_att[3:0]));
        end
        e.l   = clampv(rl, cl);
        e.r   = clampv(rr, cr);
        e.clp = cl | cr;
        e.cyc = cyc;
        sb.push_back(e);
`ifdef AUD_MIX_RAMP_EN
        for (int i = 0; i < NCH; i++) begin
            g = sat_g(int'(gain[i*8 +: 8]));
            if (c_m[i] < g) c_m[i]++;
            else if (c_m[i] > g) c_m[i]--;
        end
`endif
    endtask

    task automatic run_frame();
        @(negedge clk);
        sample_ce = 1'b1;
        push_expected();
        @(negedge clk);
        sample_ce = 1'b0;
        repeat (NCH + 5) @(negedge clk);
    endtask

    task automatic set_all(input logic [DW-1:0] v, input bit s, input logic [7:0] g);
        for (int i = 0; i < NCH; i++) begin
            in_l[i*DW +: DW] = v;
            in_r[i*DW +: DW] = v;
            is_signed[i]     = s;
            gain[i*8 +: 8]   = g;
        end
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < NCH; i++) begin
            in_l[i*DW +: DW] = DW'($urandom);
            in_r[i*DW +: DW] = DW'($urandom);
            is_signed[i]     = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       gain[i*8 +: 8] = 8'd128;
                1:       gain[i*8 +: 8] = 8'($urandom_range(0, 128));
                2:       gain[i*8 +: 8] = 8'($urandom_range(129, 255));
                default: gain[i*8 +: 8] = 8'($urandom);
            endcase
        end
        master_att = {($urandom_range(0, 7) == 0), 4'($urandom_range(0, 3))};
    endtask

    // Monitor: compare every valid output against the scoreboard, and check held values otherwise.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_l", 32'(out_l), 32'(e.l));
                    chk("out_r", 32'(out_r), 32'(e.r));
                    chk("clip", 32'(clip), 32'(e.clp));
                    chk("latency", 32'(cyc - e.cyc), 32'(NCH + 4));
                    last_l    = e.l;
                    last_r    = e.r;
                    last_clip = e.clp;
                end
            end else if (hold_en) begin
                chk("hold_l", 32'(out_l), 32'(last_l));
                chk("hold_r", 32'(out_r), 32'(last_r));
                chk("hold_clip", 32'(clip), 32'(last_clip));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NCH; i++) c_m[i] = 0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_out_l", 32'(out_l), 32'd0);
        chk("rst_out_r", 32'(out_r), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_clip", 32'(clip), 32'd0);
        hold_en = 1'b1;

        // Directed: passthrough, clamp both ways, offset binary with attenuation and mute.
        set_all(16'h0000, 1'b1, 8'd0);
        in_l[DW-1:0] = 16'h1234;
        gain[7:0]    = 8'd128;
        run_frame();
        set_all(16'h7000, 1'b1, 8'd128);
        run_frame();
        set_all(16'h9000, 1'b1, 8'd128);
        run_frame();
        set_all(16'h8000, 1'b0, 8'd0);
        in_l[DW-1:0] = 16'hC000;
        gain[7:0]    = 8'd128;
        run_frame();
        master_att = 5'h02;
        run_frame();
        master_att = 5'h10;
        run_frame();
        master_att = 5'h00;

        for (int n = 0; n < 300; n++) begin
            randomize_inputs();
            run_frame();
        end

        // Overrun: second strobe mid-frame is dropped and sets the sticky flag.
        for (int pass = 0; pass < 2; pass++) begin
            randomize_inputs();
            @(negedge clk);
            sample_ce = 1'b1;
            push_expected();
            @(negedge clk);
            sample_ce = 1'b0;
            repeat (2) @(negedge clk);
            sample_ce = 1'b1;
            ovr_clr   = (pass == 1);
            @(negedge clk);
            sample_ce = 1'b0;
            ovr_clr   = 1'b0;
            repeat (NCH + 5) @(negedge clk);
            chk("overrun_set", 32'(overrun), 32'd1);
            ovr_clr = 1'b1;
            @(negedge clk);
            ovr_clr = 1'b0;
            @(negedge clk);
            chk("overrun_clr", 32'(overrun), 32'd0);
        end

        // Reset during ACC: everything clears at once and no output is produced.
        randomize_inputs();
        master_att = 5'd0;
        @(negedge clk);
        sample_ce = 1'b1;
        @(negedge clk);
        sample_ce = 1'b0;
        @(negedge clk);
        chk("busy_in_acc", 32'(busy), 32'd1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_out_l", 32'(out_l), 32'd0);
        chk("mid_rst_out_r", 32'(out_r), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_clip", 32'(clip), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        last_l    = '0;
        last_r    = '0;
        last_clip = 1'b0;
        for (int i = 0; i < NCH; i++) c_m[i] = 0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (NCH + 6) @(negedge clk);

        // Fade-in from reset at unity, then a step down to half gain.
        set_all(16'h0000, 1'b1, 8'd0);
        in_l[DW-1:0] = 16'h4000;
        in_r[DW-1:0] = 16'hC000;
        gain[7:0]    = 8'd128;
        for (int n = 0; n < 132; n++) run_frame();
        gain[7:0] = 8'd64;
        for (int n = 0; n < 66; n++) run_frame();

        repeat (NCH + 8) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aud_mix_multi.md
# aud_mix_multi

Parametrised N-source stereo mixer, the successor to the two-input core/ALSA mixer stage in the audio output path. On each `sample_ce` it snapshots NCH stereo sources, applies a per-source linear gain with click-free ramping, and sums the sources time-multiplexed through one multiplier pair. It then applies master attenuation, clamps the result and presents a signed stereo sample with a valid strobe. It sits after the DC blockers and before the I2S/SPDIF serialisers.

## Interface
- `NCH`, 4: number of stereo sources, 1..16.
- `DW`, 16: sample width of the inputs and outputs.
- `clk` in 1: system audio clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `sample_ce` in 1: one-cycle frame start strobe.
- `in_l`, `in_r` in NCH*DW: source samples; source i occupies bits [i*DW +: DW].
- `is_signed` in NCH: per source; 1 = two's complement, 0 = offset binary.
- `gain` in NCH*8: per-source target gain, unsigned; 128 = unity; values above 128 saturate to 128.
- `master_att` in 5: bit 4 mutes the output; bits [3:0] give an arithmetic right-shift count.
- `ovr_clr` in 1: clears `overrun`.
- `out_l`, `out_r` out DW: signed mixed output; reset value 0.
- `out_valid` out 1: one-cycle pulse when a new output is loaded; reset value 0.
- `busy` out 1: high while a frame is in progress; reset value 0.
- `overrun` out 1: sticky; set when `sample_ce` arrives while `busy`; reset value 0.
- `clip` out 1: high while the current output was clamped; reset value 0.

## Operation
- **Input conversion:** each sample becomes signed by inverting its MSB when `is_signed[i]`=0.
- **State machine:** IDLE -> CAP -> ACC -> SCALE -> OUT -> IDLE.
  - IDLE: when `sample_ce` is high, go to CAP.
  - CAP: latch all `in_l`, `in_r` and `is_signed`; latch the applied gain g[i] (the current ramp value, see Configuration); clear both accumulators; set the channel index k=0.
  - ACC: accumulate acc += sx[k]*g[k] for L and R. The product is DW+9 bits signed. The accumulator is DW+9+clog2(NCH) bits, so it cannot overflow. k increments each cycle; the state lasts exactly NCH cycles.
  - SCALE: compute r = (acc >>> 7) >>> master_att[3:0], arithmetic with sign preserved. If master_att[4] is set, r = 0.
  - OUT: clamp r to the DW-bit signed range; positive overflow gives 0x7FFF and negative overflow gives 0x8000 (for DW=16). Load `out_l`/`out_r`, pulse `out_valid`, and set `clip` to (L clamped | R clamped). Update the ramp registers. Return to IDLE.
- **busy:** high in CAP, ACC, SCALE and OUT.
- **Overrun:** a `sample_ce` seen in any state other than IDLE is dropped, and `overrun` is set. `ovr_clr` clears `overrun`; if a set and a clear occur in the same cycle, set wins.
- **Held values:** `master_att` and `gain` are sampled live (`gain` in CAP, `master_att` in SCALE); a change takes effect on the next frame that reaches that state.
- **Reset mid-frame:** asynchronous; all state, outputs and ramp registers return to their reset values immediately.

## Timing
- From `sample_ce` high in cycle T: CAP in T+1, ACC in T+2..T+1+NCH, SCALE in T+2+NCH, OUT in T+3+NCH.
- `out_l`, `out_r` and `out_valid` are visible in cycle T+4+NCH.
- Minimum `sample_ce` spacing without overrun is NCH+4 cycles. At 24.576 MHz and 48 kHz there are 512 cycles per frame, which is ample for NCH<=16.
- `out_l` and `out_r` hold their value between frames.

## Configuration
- `AUD_MIX_RAMP_EN` defined:
  - Each source keeps an 8-bit current gain c[i]; c[i] resets to 0, so the mixer fades in from silence after reset.
  - In OUT, each c[i] moves one LSB toward its saturated target; it is unchanged once equal.
  - CAP uses g[i]=c[i], so a full 0->128 ramp takes 128 frames.
- `AUD_MIX_RAMP_EN` undefined:
  - No ramp registers exist, and CAP uses g[i] = the saturated `gain[i]` directly.
  - Behaviour is otherwise identical.

## Test plan
- **Ramp off, passthrough:** NCH=4, `gain`={128,0,0,0}, src0 L=0x1234 signed, `master_att`=0 -> `out_l`=0x1234 at T+8, `out_valid` high for one cycle, `clip`=0.
- **Clamp:** all four sources at 0x7000 signed with unity gain -> `out_l`=0x7FFF and `clip`=1; all at 0x9000 -> `out_l`=0x8000.
- **Master attenuation and offset binary:** src0 unsigned 0xC000 at unity gain -> 0x4000 before attenuation; with `master_att`=5'h02 -> `out_l`=0x1000; with `master_att`=5'h10 -> `out_l`=0.
- **Ramp on:** after reset with unity gain and src0=0x4000, frame 1 gives 0, frame 2 gives 0x0080, and frame 129 onward gives 0x4000. Changing `gain` from 128 to 64 then gives a monotonic decrease over 64 frames.
- **Overrun and reset:** a second `sample_ce` 3 cycles after the first -> frame completes normally, `overrun`=1; `ovr_clr` -> 0. Asserting `reset_n` low during ACC -> all outputs 0 at once and no `out_valid` pulse.
